// File: rtl/mips_mem_responder.sv
// Word-addressed memory responder: one outstanding request, fixed wait latency,
// valid/ready request and response handshakes with out-of-range error reporting.
module mips_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] mem [DEPTH];

    logic          in_range;
    logic          commit;
    logic [AW-1:0] idx;

    // Full 32-bit compare so high address bits can never alias into the array
    assign in_range = addr_q < 32'(DEPTH);
    assign idx      = addr_q[AW-1:0];
    assign commit   = (state == BUSY) && (cnt <= 4'd1);

    always_ff @(posedge clk1) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        cnt       <= LAT;
                        req_ready <= 1'b0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (commit) begin
                        cnt       <= 4'd0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= ~in_range;
                        rsp_rdata <= (in_range && !we_q) ? mem[idx] : 32'd0;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'd0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Array has no reset; a reset on the commit edge suppresses the store
    always_ff @(posedge clk1) begin
        if (!rst && commit && we_q && in_range) begin
            mem[idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Scoreboard bench for mips_mem_responder: LATENCY=2 main instance plus a
// LATENCY=1 instance for the short-latency timing case.
module tb_mips_mem_responder;

    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        b_req_valid, b_req_ready, b_req_we;
    logic [31:0] b_req_addr, b_req_wdata;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    mips_mem_responder #(.DEPTH(1024), .LATENCY(2)) dut (
        .clk1(clk1), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    mips_mem_responder #(.DEPTH(1024), .LATENCY(1)) dut1 (
        .clk1(clk1), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   hs[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk1) cyc++;

    // Scoreboard: compare every response handshake against the queued expectation
    always @(negedge clk1) begin : mon
        exp_t e;
        if (rst === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            hs.push_back(cyc);
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected got rdata=%h err=%b, none expected",
                         rsp_rdata, rsp_err);
            end else begin
                e = sb.pop_front();
                if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                    n_fail++;
                    $display("FAIL sb_rsp got rdata=%h err=%b expected rdata=%h err=%b",
                             rsp_rdata, rsp_err, e.rdata, e.err);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk1);
            #1;
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] er,
                         input logic ee, input bit push, output int acc);
        int t = 0;
        while (req_ready !== 1'b1 && t < 50) begin
            step(1);
            t++;
        end
        if (req_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout req_ready=%b expected 1", req_ready);
            acc = -1;
            return;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        if (push) sb.push_back('{er, ee});
        step(1);
        acc       = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_valid(output int e);
        int t = 0;
        while (rsp_valid !== 1'b1 && t < 50) begin
            step(1);
            t++;
        end
        e = (rsp_valid === 1'b1) ? cyc : -1;
    endtask

    task automatic drain();
        int t = 0;
        while (req_ready !== 1'b1 && t < 50) begin
            step(1);
            t++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b1;
        b_req_valid = 1'b1;
        step(2);
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 ||
            rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state got ready=%b valid=%b rdata=%h err=%b expected 1 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        n_checks++;
        if (b_req_ready !== 1'b1 || b_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state_l1 got ready=%b valid=%b expected 1 0",
                     b_req_ready, b_rsp_valid);
        end
        req_valid = 1'b0;
        b_req_valid = 1'b0;
        rst = 1'b0;
        step(1);
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release got ready=%b valid=%b expected 1 0",
                     req_ready, rsp_valid);
        end
    endtask

    task automatic test_store_load();
        int acc, e;
        issue(1'b1, 32'd5, 32'hDEADBEEF, 32'd0, 1'b0, 1'b1, acc);
        wait_valid(e);
        n_checks++;
        if (e + 1 != acc + 3) begin
            n_fail++;
            $display("FAIL store_latency got sample edge %0d expected %0d", e + 1, acc + 3);
        end
        n_checks++;
        if (rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL store_rsp got rdata=%h err=%b expected 0 0", rsp_rdata, rsp_err);
        end
        issue(1'b0, 32'd5, 32'd0, 32'hDEADBEEF, 1'b0, 1'b1, acc);
        wait_valid(e);
        n_checks++;
        if (e + 1 != acc + 3 || rsp_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL load_after_store got edge=%0d rdata=%h expected edge=%0d rdata=deadbeef",
                     e + 1, rsp_rdata, acc + 3);
        end
    endtask

    task automatic test_out_of_range();
        int acc, e;
        issue(1'b1, 32'd1023, 32'hCAFE0001, 32'd0, 1'b0, 1'b1, acc);
        issue(1'b0, 32'd1024, 32'd0, 32'd0, 1'b1, 1'b1, acc);
        wait_valid(e);
        n_checks++;
        if (rsp_err !== 1'b1 || rsp_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL oor_load got err=%b rdata=%h expected 1 0", rsp_err, rsp_rdata);
        end
        issue(1'b1, 32'hFFFF_FFFF, 32'd7, 32'd0, 1'b1, 1'b1, acc);
        wait_valid(e);
        n_checks++;
        if (rsp_err !== 1'b1 || rsp_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL oor_store got err=%b rdata=%h expected 1 0", rsp_err, rsp_rdata);
        end
        issue(1'b1, 32'd2047, 32'd9, 32'd0, 1'b1, 1'b1, acc);
        issue(1'b0, 32'd1023, 32'd0, 32'hCAFE0001, 1'b0, 1'b1, acc);
        wait_valid(e);
        n_checks++;
        if (rsp_rdata !== 32'hCAFE0001 || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_no_alias got rdata=%h err=%b expected cafe0001 0",
                     rsp_rdata, rsp_err);
        end
    endtask

    task automatic test_backpressure();
        int acc, e;
        issue(1'b1, 32'd9, 32'h99, 32'd0, 1'b0, 1'b1, acc);
        drain();
        rsp_ready = 1'b0;
        issue(1'b0, 32'd9, 32'd0, 32'h99, 1'b0, 1'b1, acc);
        wait_valid(e);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h99 || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_%0d got valid=%b rdata=%h ready=%b expected 1 00000099 0",
                         i, rsp_valid, rsp_rdata, req_ready);
            end
            if (i == 1) begin
                req_valid = 1'b1;
                req_we    = 1'b1;
                req_addr  = 32'd0;
                req_wdata = 32'hBAD;
            end
            if (i == 2) req_valid = 1'b0;
            step(1);
        end
        rsp_ready = 1'b1;
        step(1);
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release got ready=%b valid=%b expected 1 0", req_ready, rsp_valid);
        end
        step(3);
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_pulse_ignored got valid=%b ready=%b expected 0 1",
                     rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset_abort();
        int acc, e;
        issue(1'b1, 32'd3, 32'h1234, 32'd0, 1'b0, 1'b1, acc);
        drain();
        issue(1'b1, 32'd3, 32'h55, 32'd0, 1'b0, 1'b0, acc);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_state got ready=%b valid=%b expected 1 0", req_ready, rsp_valid);
        end
        step(3);
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_rsp got valid=%b expected 0", rsp_valid);
        end
        issue(1'b0, 32'd3, 32'd0, 32'h1234, 1'b0, 1'b1, acc);
        wait_valid(e);
        n_checks++;
        if (rsp_rdata !== 32'h1234) begin
            n_fail++;
            $display("FAIL abort_load got rdata=%h expected 00001234", rsp_rdata);
        end
        drain();
        rsp_ready = 1'b0;
        issue(1'b0, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, acc);
        wait_valid(e);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        rsp_ready = 1'b1;
        step(2);
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL resp_drop got valid=%b ready=%b expected 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_back_to_back();
        int acc, t;
        for (int k = 0; k < 3; k++)
            issue(1'b1, 32'(k), 32'h10 + 32'(k), 32'd0, 1'b0, 1'b1, acc);
        drain();
        hs.delete();
        req_valid = 1'b1;
        req_we    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_addr = 32'(k);
            sb.push_back('{32'h10 + 32'(k), 1'b0});
            t = 0;
            while (req_ready !== 1'b1 && t < 50) begin
                step(1);
                t++;
            end
            step(1);
        end
        req_valid = 1'b0;
        t = 0;
        while (hs.size() < 3 && t < 50) begin
            step(1);
            t++;
        end
        n_checks++;
        if (hs.size() != 3) begin
            n_fail++;
            $display("FAIL b2b_count got %0d responses expected 3", hs.size());
        end else begin
            n_checks++;
            if (hs[1] - hs[0] != 4 || hs[2] - hs[1] != 4) begin
                n_fail++;
                $display("FAIL b2b_spacing got %0d,%0d expected 4,4",
                         hs[1] - hs[0], hs[2] - hs[1]);
            end
        end
        drain();
    endtask

    task automatic test_latency1();
        int acc, e, t;
        for (int pass = 0; pass < 2; pass++) begin
            b_req_valid = 1'b1;
            b_req_we    = (pass == 0);
            b_req_addr  = 32'd7;
            b_req_wdata = 32'hA5;
            step(1);
            acc = cyc;
            b_req_valid = 1'b0;
            t = 0;
            while (b_rsp_valid !== 1'b1 && t < 50) begin
                step(1);
                t++;
            end
            e = (b_rsp_valid === 1'b1) ? cyc : -1;
            n_checks++;
            if (e + 1 != acc + 2 ||
                b_rsp_rdata !== ((pass == 0) ? 32'd0 : 32'hA5) || b_rsp_err !== 1'b0) begin
                n_fail++;
                $display("FAIL lat1_pass%0d got edge=%0d rdata=%h err=%b expected edge=%0d rdata=%h",
                         pass, e + 1, b_rsp_rdata, b_rsp_err, acc + 2,
                         (pass == 0) ? 32'd0 : 32'hA5);
            end
            t = 0;
            while (b_req_ready !== 1'b1 && t < 50) begin
                step(1);
                t++;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        rsp_ready = 1'b1;
        b_req_valid = 1'b0;
        b_req_we = 1'b0;
        b_req_addr = 32'd0;
        b_req_wdata = 32'd0;
        b_rsp_ready = 1'b1;
        @(posedge clk1);
        #1;
        test_reset();
        test_store_load();
        test_out_of_range();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        test_latency1();
        step(3);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
